// File: rtl/stream_demux.sv
// 1-to-2 stream demultiplexer with an independent show-ahead FIFO per output.
// Define DEMUX_STATS_EN to add saturating per-output pop counters (out0_count/out1_count).
module stream_demux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] out0_count,
    output logic [CNT_W-1:0] out1_count
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [CW-1:0]    cnt_q    [2];
    logic [CW-1:0]    cnt_d    [2];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;

    assign out_ready = {out1_ready, out0_ready};

    // in_ready looks only at registered fullness, so a same-cycle pop never frees a slot.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            full[k]  = (cnt_q[k] == CW'(DEPTH));
            empty[k] = (cnt_q[k] == '0);
        end
        in_ready = !rst && !full[in_sel];
        push[0]  = in_valid && in_ready && !in_sel;
        push[1]  = in_valid && in_ready && in_sel;
        pop      = ~empty & out_ready;
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wr_ptr_d[k] = push[k] ? wr_ptr_q[k] + PTR_W'(1) : wr_ptr_q[k];
            rd_ptr_d[k] = pop[k] ? rd_ptr_q[k] + PTR_W'(1) : rd_ptr_q[k];
            unique case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= in_data;
            end
        end
    end

    assign out0_valid = !empty[0];
    assign out1_valid = !empty[1];
    assign out0_data  = empty[0] ? '0 : mem_q[0][rd_ptr_q[0]];
    assign out1_data  = empty[1] ? '0 : mem_q[1][rd_ptr_q[1]];

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] stat_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q[0] <= '0;
            stat_q[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pop[k] && (stat_q[k] != '1)) begin
                    stat_q[k] <= stat_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign out0_count = stat_q[0];
    assign out1_count = stat_q[1];
`else
    // CNT_W only sizes the optional counters.
    logic [CNT_W-1:0] unused_stats;
    assign unused_stats = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed table-driven bench for stream_demux plus a modelled alternating-stream run.
module tb_stream_demux;

    localparam int unsigned TB_CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;
    logic        out0_valid;
    logic        out0_ready;
    logic [31:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [31:0] out1_data;
`ifdef DEMUX_STATS_EN
    logic [TB_CNT_W-1:0] out0_count;
    logic [TB_CNT_W-1:0] out1_count;
`endif

    stream_demux #(
        .WIDTH (32),
        .DEPTH (4),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
        ,
        .out0_count (out0_count),
        .out1_count (out1_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic        sel;
        logic [31:0] d;
        logic        r0;
        logic        r1;
        logic        e_ir;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t row(logic r, logic v, logic s, logic [31:0] d, logic r0, logic r1,
                                 logic ir, logic v0, logic [31:0] d0, logic v1, logic [31:0] d1);
        vec_t x;
        x.rst = r; x.v = v; x.sel = s; x.d = d; x.r0 = r0; x.r1 = r1;
        x.e_ir = ir; x.e_v0 = v0; x.e_d0 = d0; x.e_v1 = v1; x.e_d1 = d1;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ir, input logic v0,
                              input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        check({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, ir});
        check({tag, " out0_valid"}, {31'd0, out0_valid}, {31'd0, v0});
        check({tag, " out0_data"}, out0_data, d0);
        check({tag, " out1_valid"}, {31'd0, out1_valid}, {31'd0, v1});
        check({tag, " out1_data"}, out1_data, d1);
    endtask

    logic [31:0] m0[$];
    logic [31:0] m1[$];
    logic [31:0] got0[$];
    logic [31:0] got1[$];

    initial begin
        // Pre-edge expectations: outputs reflect state before the edge that applies the row.
        // Test 1: single word, visible exactly one cycle.
        tbl.push_back(row(0, 1, 0, 32'h11111111, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 0, 1, 1, 32'h11111111, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        // Test 2: fill output 1, output 0 still flows.
        tbl.push_back(row(0, 1, 1, 32'hA0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'hA1, 0, 0, 1, 0, 0, 1, 32'hA0));
        tbl.push_back(row(0, 1, 1, 32'hA2, 0, 0, 1, 0, 0, 1, 32'hA0));
        tbl.push_back(row(0, 1, 1, 32'hA3, 0, 0, 1, 0, 0, 1, 32'hA0));
        tbl.push_back(row(0, 1, 1, 32'hA4, 0, 0, 0, 0, 0, 1, 32'hA0));
        tbl.push_back(row(0, 1, 0, 32'hB0, 0, 0, 1, 0, 0, 1, 32'hA0));
        // Test 3: full + pop same cycle refuses the push.
        tbl.push_back(row(0, 1, 1, 32'hA5, 0, 1, 0, 1, 32'hB0, 1, 32'hA0));
        tbl.push_back(row(0, 1, 1, 32'hA5, 0, 0, 1, 1, 32'hB0, 1, 32'hA1));
        tbl.push_back(row(0, 0, 0, 0, 1, 1, 1, 1, 32'hB0, 1, 32'hA1));
        tbl.push_back(row(0, 1, 1, 32'hA6, 0, 1, 1, 0, 0, 1, 32'hA2));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'hA3));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'hA5));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'hA6));
        // Ready on empty FIFOs must be harmless.
        tbl.push_back(row(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 32'hC0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 1, 32'hC0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 1, 0, 1, 1, 32'hC0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        // Test 5: mid-stream reset with two words in each FIFO.
        tbl.push_back(row(0, 1, 0, 32'hD0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 32'hD1, 0, 0, 1, 1, 32'hD0, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'hE0, 0, 0, 1, 1, 32'hD0, 0, 0));
        tbl.push_back(row(0, 1, 1, 32'hE1, 0, 0, 1, 1, 32'hD0, 1, 32'hE0));
        tbl.push_back(row(1, 1, 0, 32'hDEAD, 1, 1, 0, 1, 32'hD0, 1, 32'hE0));
        tbl.push_back(row(0, 1, 1, 32'hF0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'hF0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outs("reset", 1, 0, 0, 0, 0);
`ifdef DEMUX_STATS_EN
        check("reset out0_count", 32'(out0_count), 0);
        check("reset out1_count", 32'(out1_count), 0);
`endif
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].v; in_sel = tbl[i].sel; in_data = tbl[i].d;
            out0_ready = tbl[i].r0; out1_ready = tbl[i].r1;
            @(negedge clk);
            check_outs($sformatf("row%0d", i), tbl[i].e_ir, tbl[i].e_v0, tbl[i].e_d0,
                       tbl[i].e_v1, tbl[i].e_d1);
            @(posedge clk); #1;
        end

        // Test 4: 10 alternating words, random readys, checked against a queue model.
        rst = 1'b1; in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        begin
            int sent = 0;
            int cyc = 0;
            logic exp_ir, pu, p0, p1;
            while ((sent < 10 || m0.size() != 0 || m1.size() != 0) && cyc < 300) begin
                in_valid = (sent < 10);
                in_sel = sent[0];
                in_data = 32'hC0DE0000 + 32'(sent);
                out0_ready = 1'($urandom_range(0, 1));
                out1_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                exp_ir = in_sel ? (m1.size() < 4) : (m0.size() < 4);
                check("stream in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
                check("stream out0_valid", {31'd0, out0_valid}, {31'd0, m0.size() != 0});
                check("stream out0_data", out0_data, (m0.size() != 0) ? m0[0] : 32'd0);
                check("stream out1_valid", {31'd0, out1_valid}, {31'd0, m1.size() != 0});
                check("stream out1_data", out1_data, (m1.size() != 0) ? m1[0] : 32'd0);
                pu = in_valid && exp_ir;
                p0 = (m0.size() != 0) && out0_ready;
                p1 = (m1.size() != 0) && out1_ready;
                @(posedge clk);
                if (p0) got0.push_back(m0.pop_front());
                if (p1) got1.push_back(m1.pop_front());
                if (pu) begin
                    if (in_sel) m1.push_back(in_data);
                    else m0.push_back(in_data);
                    sent++;
                end
                #1 cyc++;
            end
            in_valid = 1'b0;
            if (cyc >= 300) begin
                errors++;
                checks++;
                $display("FAIL stream timeout: got %0d cycles expected under 300", cyc);
            end
            check("stream out0 words", 32'(got0.size()), 5);
            check("stream out1 words", 32'(got1.size()), 5);
            for (int i = 0; i < got0.size() && i < 5; i++)
                check("stream out0 order", got0[i], 32'hC0DE0000 + 32'(2 * i));
            for (int i = 0; i < got1.size() && i < 5; i++)
                check("stream out1 order", got1[i], 32'hC0DE0001 + 32'(2 * i));
        end
`ifdef DEMUX_STATS_EN
        @(negedge clk);
        check("stats out0_count", 32'(out0_count), (TB_CNT_W >= 3) ? 5 : (1 << TB_CNT_W) - 1);
        check("stats out1_count", 32'(out1_count), (TB_CNT_W >= 3) ? 5 : (1 << TB_CNT_W) - 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
